// File: rtl/imem_loadable.sv
// Loadable instruction memory: boot/debug load port with auto-incrementing pointer,
// plus a 1- or 2-stage fetch pipeline with stall, valid and misaligned-fetch flag.
module imem_loadable #(
  parameter int               INS_ADDRESS = 9,
  parameter int               INS_W       = 32,
  parameter int               RD_LAT      = 1,
  parameter logic [INS_W-1:0] NOP_WORD    = 32'h00000013
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   ld_start,
  input  logic                   ld_valid,
  input  logic [INS_W-1:0]       ld_data,
  input  logic                   ld_last,
  output logic                   ld_ready,
  output logic                   ld_done,
  input  logic                   fetch_en,
  input  logic [INS_ADDRESS-1:0] ra,
  input  logic                   stall,
  output logic [INS_W-1:0]       rd,
  output logic                   rd_valid,
  output logic                   misalign_err,
  output logic                   busy
);
  localparam int IDX_W = INS_ADDRESS - 2;
  localparam int DEPTH = 1 << IDX_W;

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_LOAD = 1'b1;

  generate
    if (RD_LAT != 1 && RD_LAT != 2) begin : g_bad_rd_lat
      $error("imem_loadable: RD_LAT must be 1 or 2");
    end
  endgenerate

  logic [INS_W-1:0] mem_array [DEPTH];

  logic [0:0]       state_reg, state_next;
  logic [IDX_W-1:0] ptr_reg, ptr_next;
  logic             ld_done_reg, ld_done_next;
  logic             in_load;
  logic             ld_accept;
  logic             ld_finish;
  logic [IDX_W-1:0] wr_idx;

  assign in_load   = (state_reg == ST_LOAD);
  assign ld_accept = in_load && ld_valid;
  // A restart that coincides with a word writes that word at index 0.
  assign wr_idx    = ld_start ? '0 : ptr_reg;
  assign ld_finish = ld_accept && (ld_last || (&wr_idx));

  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    ld_done_next = 1'b0;
    if (in_load) begin
      if (ld_accept) begin
        ptr_next = wr_idx + IDX_W'(1);
      end else if (ld_start) begin
        ptr_next = '0;
      end
      if (ld_finish) begin
        state_next   = ST_RUN;
        ld_done_next = 1'b1;
        ptr_next     = '0;
      end
    end else if (ld_start) begin
      state_next = ST_LOAD;
      ptr_next   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg   <= ST_RUN;
      ptr_reg     <= '0;
      ld_done_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ptr_reg     <= ptr_next;
      ld_done_reg <= ld_done_next;
    end
  end

  // Storage is deliberately outside the reset so contents survive an aborted load.
  always_ff @(posedge clk) begin
    if (reset && ld_accept) begin
      mem_array[wr_idx] <= ld_data;
    end
  end

  assign busy     = in_load;
  assign ld_ready = in_load;
  assign ld_done  = ld_done_reg;

  logic             fetch_accept;
  logic             req_misaligned;
  logic             s1_valid_reg;
  logic             s1_mis_reg;
  logic [INS_W-1:0] s1_data_reg;

  assign req_misaligned = (ra[1:0] != 2'b00);
  assign fetch_accept   = !in_load && !ld_start && fetch_en && !stall;

  // Stage 1 holds the registered memory read; data only updates on an accepted fetch.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1_valid_reg <= 1'b0;
      s1_mis_reg   <= 1'b0;
      s1_data_reg  <= '0;
    end else if (ld_start) begin
      s1_valid_reg <= 1'b0;
      s1_mis_reg   <= 1'b0;
    end else if (!stall) begin
      s1_valid_reg <= fetch_accept;
      s1_mis_reg   <= fetch_accept && req_misaligned;
      if (fetch_accept) begin
        s1_data_reg <= req_misaligned ? NOP_WORD : mem_array[ra[INS_ADDRESS-1:2]];
      end
    end
  end

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic             s2_valid_reg;
      logic             s2_mis_reg;
      logic [INS_W-1:0] s2_data_reg;

      always_ff @(posedge clk) begin
        if (!reset) begin
          s2_valid_reg <= 1'b0;
          s2_mis_reg   <= 1'b0;
          s2_data_reg  <= '0;
        end else if (ld_start) begin
          s2_valid_reg <= 1'b0;
          s2_mis_reg   <= 1'b0;
        end else if (!stall) begin
          s2_valid_reg <= s1_valid_reg;
          s2_mis_reg   <= s1_mis_reg;
          if (s1_valid_reg) begin
            s2_data_reg <= s1_data_reg;
          end
        end
      end

      assign rd           = s2_data_reg;
      assign rd_valid     = s2_valid_reg;
      assign misalign_err = s2_mis_reg;
    end else begin : g_lat1
      assign rd           = s1_data_reg;
      assign rd_valid     = s1_valid_reg;
      assign misalign_err = s1_mis_reg;
    end
  endgenerate

endmodule

// File: tb/tb_imem_loadable.sv
// Bench for imem_loadable: one instance per fetch latency sharing all inputs,
// responses checked against a queue of expected {misalign, word} values.
module tb_imem_loadable;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_start, ld_valid, ld_last, fetch_en, stall;
  logic [31:0] ld_data;
  logic [8:0]  ra;

  logic        ld_ready1, ld_done1, rd_valid1, misalign_err1, busy1;
  logic        ld_ready2, ld_done2, rd_valid2, misalign_err2, busy2;
  logic [31:0] rd1, rd2;

  imem_loadable #(.RD_LAT(1)) dut1 (
    .clk(clk), .reset(reset), .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(ld_ready1), .ld_done(ld_done1), .fetch_en(fetch_en), .ra(ra),
    .stall(stall), .rd(rd1), .rd_valid(rd_valid1), .misalign_err(misalign_err1), .busy(busy1)
  );

  imem_loadable #(.RD_LAT(2)) dut2 (
    .clk(clk), .reset(reset), .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(ld_ready2), .ld_done(ld_done2), .fetch_en(fetch_en), .ra(ra),
    .stall(stall), .rd(rd2), .rd_valid(rd_valid2), .misalign_err(misalign_err2), .busy(busy2)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_mem [128];
  logic [31:0] ld_buf [128];
  logic [32:0] q1 [$];
  logic [32:0] q2 [$];
  logic [33:0] resp [2];
  logic [33:0] prev_resp [2];
  logic        edge_stall;

  always_comb begin
    resp[0] = {rd_valid1, misalign_err1, rd1};
    resp[1] = {rd_valid2, misalign_err2, rd2};
  end

  function automatic void push_exp(input logic [8:0] a);
    logic        mis;
    logic [32:0] e;
    mis = (a[1:0] != 2'b00);
    e   = {mis, mis ? NOP : model_mem[a[8:2]]};
    q1.push_back(e);
    q2.push_back(e);
  endfunction

  function automatic bit pop_exp(input int d, output logic [32:0] e);
    e = '0;
    if (d == 0) begin
      if (q1.size() == 0) return 1'b0;
      e = q1.pop_front();
    end else begin
      if (q2.size() == 0) return 1'b0;
      e = q2.pop_front();
    end
    return 1'b1;
  endfunction

  // Drives one fetch-side cycle and records the expectation; called right after a negedge.
  task automatic drive_cycle(input logic st, input logic fen, input logic [8:0] a, input logic ls);
    stall      = st;
    fetch_en   = fen;
    ra         = a;
    ld_start   = ls;
    edge_stall = st;
    if (ls) begin
      q1.delete();
      q2.delete();
    end else if (fen && !st && !busy1) begin
      push_exp(a);
    end
    @(negedge clk);
    ld_start = 1'b0;
  endtask

  task automatic do_load(input int n, input bit use_last, output logic [5:0] status);
    logic ready_ok, early_done;
    ready_ok   = 1'b1;
    early_done = 1'b0;
    stall      = 1'b0;
    fetch_en   = 1'b0;
    ld_start   = 1'b1;
    @(negedge clk);
    ld_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      ready_ok = ready_ok && (ld_ready1 === 1'b1) && (busy1 === 1'b1) && (busy2 === 1'b1);
      if (ld_done1 !== 1'b0) early_done = 1'b1;
      ld_valid     = 1'b1;
      ld_data      = ld_buf[i];
      ld_last      = use_last && (i == n - 1);
      model_mem[i] = ld_buf[i];
      @(negedge clk);
    end
    ld_valid  = 1'b0;
    ld_last   = 1'b0;
    status[5] = ready_ok;
    status[4] = early_done;
    status[3] = ld_done1;
    status[2] = ld_ready1;
    status[1] = busy1;
    @(negedge clk);
    status[0] = ld_done1;
  endtask

  task automatic test_reset;
    reset    = 1'b0;
    ld_start = 1'b1;
    fetch_en = 1'b1;
    ld_valid = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({rd1, rd_valid1, misalign_err1, ld_ready1, ld_done1, busy1} !== 37'd0) begin
      errors++;
      $display("FAIL reset_dut1 got rd=%h v=%b m=%b rdy=%b done=%b busy=%b want all 0",
               rd1, rd_valid1, misalign_err1, ld_ready1, ld_done1, busy1);
    end
    checks++;
    if ({rd2, rd_valid2, misalign_err2, ld_ready2, ld_done2, busy2} !== 37'd0) begin
      errors++;
      $display("FAIL reset_dut2 got rd=%h v=%b m=%b rdy=%b done=%b busy=%b want all 0",
               rd2, rd_valid2, misalign_err2, ld_ready2, ld_done2, busy2);
    end
    reset    = 1'b1;
    ld_start = 1'b0;
    fetch_en = 1'b0;
    ld_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy1, rd_valid1, rd_valid2} !== 3'b000) begin
      errors++;
      $display("FAIL reset_release got busy=%b v1=%b v2=%b want 000", busy1, rd_valid1, rd_valid2);
    end
  endtask

  task automatic test_load_init;
    logic [5:0] st;
    ld_buf[0] = 32'h00007033;
    ld_buf[1] = 32'h00100093;
    do_load(2, 1'b1, st);
    $display("txn load_init words=2 status=%b", st);
    checks++;
    if (st !== 6'b101000) begin
      errors++;
      $display("FAIL load_init_status got %b want 101000", st);
    end
  endtask

  task automatic test_fetch_basic;
    logic [8:0]  a_tab [6];
    logic        fen_tab [6];
    logic [32:0] e;
    logic        prev_fen;
    a_tab    = '{9'h000, 9'h004, 9'h000, 9'h000, 9'h000, 9'h000};
    fen_tab  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    prev_fen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      drive_cycle(1'b0, fen_tab[c], a_tab[c], 1'b0);
      checks++;
      if ({rd_valid1, rd_valid2} !== {fen_tab[c], prev_fen}) begin
        errors++;
        $display("FAIL basic_latency cycle %0d got v1=%b v2=%b want %b %b",
                 c, rd_valid1, rd_valid2, fen_tab[c], prev_fen);
      end
      prev_fen = fen_tab[c];
      for (int d = 0; d < 2; d++) begin
        if (resp[d][33]) begin
          checks++;
          if (!pop_exp(d, e)) begin
            errors++;
            $display("FAIL basic_extra dut%0d got %h want no response", d, resp[d][32:0]);
          end else if (resp[d][32:0] !== e) begin
            errors++;
            $display("FAIL basic_resp dut%0d got %h want %h", d, resp[d][32:0], e);
          end else begin
            $display("txn basic dut%0d mis=%b rd=%h", d, e[32], e[31:0]);
          end
        end
      end
    end
    checks++;
    if (rd1 !== 32'h00100093 || rd2 !== 32'h00100093) begin
      errors++;
      $display("FAIL basic_hold got rd1=%h rd2=%h want 00100093", rd1, rd2);
    end
    checks++;
    if (q1.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("FAIL basic_lost got pending %0d/%0d want 0/0", q1.size(), q2.size());
    end
  endtask

  task automatic test_full_load;
    logic [5:0]  st;
    logic [8:0]  a_tab [8];
    logic [32:0] e;
    for (int i = 0; i < 128; i++) ld_buf[i] = {16'hC0DE, 8'(i), 8'(255 - i)};
    do_load(128, 1'b0, st);
    $display("txn full_load words=128 status=%b", st);
    checks++;
    if (st !== 6'b101000) begin
      errors++;
      $display("FAIL full_load_status got %b want 101000", st);
    end
    a_tab = '{9'h1FC, 9'h000, 9'h0FC, 9'h100, 9'h014, 9'h000, 9'h000, 9'h000};
    for (int c = 0; c < 8; c++) begin
      drive_cycle(1'b0, (c < 5), a_tab[c], 1'b0);
      for (int d = 0; d < 2; d++) begin
        if (resp[d][33]) begin
          checks++;
          if (!pop_exp(d, e)) begin
            errors++;
            $display("FAIL full_extra dut%0d got %h want no response", d, resp[d][32:0]);
          end else if (resp[d][32:0] !== e) begin
            errors++;
            $display("FAIL full_resp dut%0d got %h want %h", d, resp[d][32:0], e);
          end else begin
            $display("txn full dut%0d mis=%b rd=%h", d, e[32], e[31:0]);
          end
        end
      end
    end
    checks++;
    if (q1.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("FAIL full_lost got pending %0d/%0d want 0/0", q1.size(), q2.size());
    end
  endtask

  task automatic test_stall;
    logic [32:0] e;
    int          issued;
    logic        st, fen;
    logic [8:0]  a;
    issued = 0;
    for (int d = 0; d < 2; d++) prev_resp[d] = resp[d];
    for (int c = 0; c < 14; c++) begin
      st  = (c >= 3 && c <= 5);
      fen = st || (issued < 8);
      a   = st ? 9'h1F0 : 9'(issued * 4);
      if (!st && fen) issued++;
      drive_cycle(st, fen, a, 1'b0);
      for (int d = 0; d < 2; d++) begin
        if (edge_stall) begin
          checks++;
          if (resp[d] !== prev_resp[d]) begin
            errors++;
            $display("FAIL stall_hold dut%0d cycle %0d got %h want %h", d, c, resp[d], prev_resp[d]);
          end
        end else if (resp[d][33]) begin
          checks++;
          if (!pop_exp(d, e)) begin
            errors++;
            $display("FAIL stall_extra dut%0d got %h want no response", d, resp[d][32:0]);
          end else if (resp[d][32:0] !== e) begin
            errors++;
            $display("FAIL stall_resp dut%0d got %h want %h", d, resp[d][32:0], e);
          end else begin
            $display("txn stall dut%0d mis=%b rd=%h", d, e[32], e[31:0]);
          end
        end
        prev_resp[d] = resp[d];
      end
    end
    checks++;
    if (q1.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("FAIL stall_lost got pending %0d/%0d want 0/0", q1.size(), q2.size());
    end
  endtask

  task automatic test_load_last_and_misalign;
    logic [5:0]  st;
    logic [8:0]  a_tab [11];
    logic        fen_tab [11];
    logic [32:0] e;
    for (int i = 0; i < 3; i++) ld_buf[i] = 32'hAAAA0001 + 32'(i);
    do_load(3, 1'b1, st);
    $display("txn load_last words=3 status=%b", st);
    checks++;
    if (st !== 6'b101000) begin
      errors++;
      $display("FAIL load_last_status got %b want 101000", st);
    end
    a_tab   = '{9'h000, 9'h004, 9'h008, 9'h000, 9'h006, 9'h004, 9'h00B, 9'h008, 9'h1FF, 9'h000, 9'h000};
    fen_tab = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int c = 0; c < 11; c++) begin
      drive_cycle(1'b0, fen_tab[c], a_tab[c], 1'b0);
      for (int d = 0; d < 2; d++) begin
        if (resp[d][33]) begin
          checks++;
          if (!pop_exp(d, e)) begin
            errors++;
            $display("FAIL mis_extra dut%0d got %h want no response", d, resp[d][32:0]);
          end else if (resp[d][32:0] !== e) begin
            errors++;
            $display("FAIL mis_resp dut%0d got %h want %h", d, resp[d][32:0], e);
          end else begin
            $display("txn fetch dut%0d mis=%b rd=%h", d, e[32], e[31:0]);
          end
        end
      end
    end
    checks++;
    if (q1.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("FAIL mis_lost got pending %0d/%0d want 0/0", q1.size(), q2.size());
    end
  endtask

  task automatic test_collide_restart;
    logic [32:0] e;
    logic [31:0] d_tab [4];
    logic        ls_tab [4];
    logic        done_early;
    logic        resp_seen;
    d_tab  = '{32'h11110000, 32'h22220000, 32'h33330000, 32'h44440000};
    ls_tab = '{1'b0, 1'b0, 1'b1, 1'b0};
    done_early = 1'b0;
    resp_seen  = 1'b0;
    for (int c = 0; c < 2; c++) begin
      drive_cycle(1'b0, 1'b1, (c == 0) ? 9'h000 : 9'h010, (c == 1));
      for (int d = 0; d < 2; d++) begin
        if (resp[d][33]) begin
          checks++;
          if (!pop_exp(d, e)) begin
            errors++;
            $display("FAIL collide_extra dut%0d got %h want no response", d, resp[d][32:0]);
          end else if (resp[d][32:0] !== e) begin
            errors++;
            $display("FAIL collide_resp dut%0d got %h want %h", d, resp[d][32:0], e);
          end else begin
            $display("txn collide dut%0d mis=%b rd=%h", d, e[32], e[31:0]);
          end
        end
      end
    end
    checks++;
    if (busy1 !== 1'b1 || busy2 !== 1'b1) begin
      errors++;
      $display("FAIL collide_busy got %b %b want 1 1", busy1, busy2);
    end
    // Fetches during the load must be ignored.
    fetch_en = 1'b1;
    ra       = 9'h004;
    for (int i = 0; i < 4; i++) begin
      ld_start = ls_tab[i];
      ld_valid = 1'b1;
      ld_data  = d_tab[i];
      ld_last  = (i == 3);
      @(negedge clk);
      if (i < 3 && ld_done1 !== 1'b0) done_early = 1'b1;
      if (rd_valid1 !== 1'b0 || rd_valid2 !== 1'b0) resp_seen = 1'b1;
    end
    model_mem[0] = 32'h33330000;
    model_mem[1] = 32'h44440000;
    checks++;
    if ({done_early, resp_seen, ld_done1, busy1, ld_ready1} !== 5'b00100) begin
      errors++;
      $display("FAIL restart_status got early=%b resp=%b done=%b busy=%b rdy=%b want 0 0 1 0 0",
               done_early, resp_seen, ld_done1, busy1, ld_ready1);
    end
    ld_start = 1'b0;
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    fetch_en = 1'b0;
    for (int c = 0; c < 5; c++) begin
      drive_cycle(1'b0, (c < 2), (c == 1) ? 9'h004 : 9'h000, 1'b0);
      for (int d = 0; d < 2; d++) begin
        if (resp[d][33]) begin
          checks++;
          if (!pop_exp(d, e)) begin
            errors++;
            $display("FAIL restart_extra dut%0d got %h want no response", d, resp[d][32:0]);
          end else if (resp[d][32:0] !== e) begin
            errors++;
            $display("FAIL restart_resp dut%0d got %h want %h", d, resp[d][32:0], e);
          end else begin
            $display("txn restart dut%0d mis=%b rd=%h", d, e[32], e[31:0]);
          end
        end
      end
    end
    checks++;
    if (q1.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("FAIL restart_lost got pending %0d/%0d want 0/0", q1.size(), q2.size());
    end
  endtask

  task automatic test_reset_abort;
    logic [32:0] e;
    logic        done_seen;
    done_seen = 1'b0;
    stall     = 1'b0;
    fetch_en  = 1'b0;
    ld_start  = 1'b1;
    @(negedge clk);
    ld_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ld_valid     = 1'b1;
      ld_data      = 32'hBEEF0000 + 32'(i);
      model_mem[i] = 32'hBEEF0000 + 32'(i);
      @(negedge clk);
    end
    ld_valid = 1'b0;
    reset    = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy1, busy2, ld_done1, ld_ready1, rd_valid1, rd_valid2} !== 6'b000000) begin
      errors++;
      $display("FAIL abort_reset got busy=%b%b done=%b rdy=%b v=%b%b want all 0",
               busy1, busy2, ld_done1, ld_ready1, rd_valid1, rd_valid2);
    end
    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (ld_done1 !== 1'b0 || ld_done2 !== 1'b0) done_seen = 1'b1;
    end
    checks++;
    if (done_seen !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL abort_done got done_seen=%b busy=%b want 0 0", done_seen, busy1);
    end
    for (int c = 0; c < 9; c++) begin
      drive_cycle(1'b0, (c < 6), 9'(c * 4), 1'b0);
      for (int d = 0; d < 2; d++) begin
        if (resp[d][33]) begin
          checks++;
          if (!pop_exp(d, e)) begin
            errors++;
            $display("FAIL abort_extra dut%0d got %h want no response", d, resp[d][32:0]);
          end else if (resp[d][32:0] !== e) begin
            errors++;
            $display("FAIL abort_resp dut%0d got %h want %h", d, resp[d][32:0], e);
          end else begin
            $display("txn abort dut%0d mis=%b rd=%h", d, e[32], e[31:0]);
          end
        end
      end
    end
    checks++;
    if (q1.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("FAIL abort_lost got pending %0d/%0d want 0/0", q1.size(), q2.size());
    end
  endtask

  initial begin
    reset      = 1'b0;
    ld_start   = 1'b0;
    ld_valid   = 1'b0;
    ld_last    = 1'b0;
    ld_data    = '0;
    fetch_en   = 1'b0;
    stall      = 1'b0;
    ra         = '0;
    edge_stall = 1'b0;
    @(negedge clk);
    test_reset;
    test_load_init;
    test_fetch_basic;
    test_full_load;
    test_stall;
    test_load_last_and_misalign;
    test_collide_restart;
    test_reset_abort;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no completion want finish within 200000 time units");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/imem_loadable.md
Name: imem_loadable

Overview:
- Parametrised successor to the single-port fetch-only instruction memory.
- Word-organised instruction store with a boot/debug program-load port, auto-incrementing load pointer and early-terminate.
- Fetch path has configurable read latency (1 or 2 cycles), a stall/hold handshake, output valid qualification, and misaligned-fetch detection.
- Sits between the PC/fetch stage and the decoder; the load port is driven by the boot loader/debug UART bridge.

Parameters:
- INS_ADDRESS, 9: byte-address width of ra; depth = 2^(INS_ADDRESS-2) words.
- INS_W, 32: instruction word width.
- RD_LAT, 1: fetch latency in cycles; legal values 1 or 2. Any other value is a synthesis-time error.
- NOP_WORD, 32'h00000013: word returned on a misaligned fetch (addi x0,x0,0).

Ports:
- clk, input, 1: clock; all logic on the rising edge.
- reset, input, 1: synchronous, active-low reset.
- ld_start, input, 1: pulse; enter/restart LOAD with pointer 0.
- ld_valid, input, 1: load word present.
- ld_data, input, INS_W: load word.
- ld_last, input, 1: qualifies ld_valid; this word is the final one.
- ld_ready, output, 1: LOAD accepts a word this cycle.
- ld_done, output, 1: one-cycle pulse when a load completes.
- fetch_en, input, 1: fetch request for ra.
- ra, input, INS_ADDRESS: byte address from the PC.
- stall, input, 1: freeze the fetch pipeline and hold its outputs.
- rd, output, INS_W: fetched instruction.
- rd_valid, output, 1: rd is a valid response.
- misalign_err, output, 1: the response belongs to a fetch with ra[1:0] != 0.
- busy, output, 1: high in LOAD; fetches are not serviced.

Behaviour:
- Storage: 2^(INS_ADDRESS-2) x INS_W array, word index ra[INS_ADDRESS-1:2]. Contents are not cleared by reset. The array may be preloaded from a hex file at elaboration.
- Reset (reset==0 at a clk edge):
  - rd=0, rd_valid=0, misalign_err=0, ld_ready=0, ld_done=0, busy=0.
  - State=RUN, load pointer=0, all pipeline valid bits cleared.
  - Reset during LOAD aborts it; words already written are retained and ld_done is not pulsed.
- FSM, RUN:
  - ld_start -> LOAD next cycle; pointer=0.
  - In-flight fetches are flushed: rd_valid=0 from the next cycle; rd holds its last value.
- FSM, LOAD:
  - busy=1, ld_ready=1.
  - On ld_valid&&ld_ready: mem[ptr]<=ld_data, ptr<=ptr+1.
  - The load finishes when ld_last accompanies an accepted word, or when the accepted word is at ptr==depth-1. Then: ld_done=1 for one cycle, state returns to RUN, ld_ready drops the same cycle ld_done rises.
  - ld_start in LOAD restarts with ptr=0. If ld_start and ld_valid coincide, the word is written at address 0 and ptr becomes 1.
  - The pointer never wraps; reaching depth-1 always terminates the load.
  - fetch_en is ignored in LOAD.
- Fetch pipeline (RUN only), RD_LAT stages:
  - A request is accepted when fetch_en && !stall; stage 1 captures the index and ra[1:0]!=0.
  - rd, rd_valid and misalign_err present the response exactly RD_LAT cycles after acceptance. The memory read occurs in stage 1; stage 2 (RD_LAT=2) is a register.
  - If !fetch_en && !stall, a bubble propagates: rd_valid=0 and rd holds its value.
  - If stall=1, no stage advances. rd, rd_valid and misalign_err hold exactly, and ra/fetch_en are ignored.
  - Misaligned request: rd=NOP_WORD, misalign_err=1, rd_valid=1. The memory contents are not used.
  - Back-to-back accepted requests give one response per cycle (full throughput).
- ld_start on the same cycle as an accepted fetch: LOAD wins, the fetch is discarded and no response is produced.

Test Plan:
- Reset then RD_LAT=1: fetch ra=0x000, 0x004 on consecutive cycles with mem[0]=0x00007033, mem[1]=0x00100093 -> rd=0x00007033 at cycle+1, then 0x00100093, rd_valid=1 both cycles.
- RD_LAT=2, stall asserted for 3 cycles mid-stream -> rd/rd_valid frozen for 3 cycles, no response lost or duplicated, order preserved.
- ld_start, 3 words 0xAAAA0001..3 with ld_last on the third -> ld_done pulse, busy=0; fetches of 0x0/0x4/0x8 return 0xAAAA0001..3.
- Fetch ra=0x006 -> rd=0x00000013, misalign_err=1, rd_valid=1; the next aligned fetch has misalign_err=0.
- Full-depth load (128 words, no ld_last) -> ld_done after the 128th word, ld_ready=0 afterwards; word 127 is readable at ra=0x1FC.
- reset low after 5 words of a load -> busy=0 and rd_valid=0 next cycle, no ld_done; words 0-4 hold the new data, word 5 is unchanged.
